// File: rtl/cluster_cken_sequencer_if.sv
// Request/handshake bundle between the cluster clock-enable sequencer and
// its requester. The master is the requester side: it drives the target
// pattern and the update/debug-init requests. The slave (the sequencer)
// returns the acknowledges, busy, and the levels sent to the cluster headers.
//   cken_target  : requested per-cluster enable pattern
//   update_req/update_ack   : four-phase handshake that applies cken_target
//   dbginit_req/dbginit_ack : four-phase handshake for a debug-init pulse
//   cluster_cken : per-cluster clock enables sent to the headers
//   grst_l       : global reset level sent to the headers
//   gdbginit_l   : global debug-init level sent to the headers
//   busy         : high whenever the sequencer is not idle
interface cluster_cken_sequencer_if #(
  parameter int NUM_CL = 4
);
  logic [NUM_CL-1:0] cken_target;
  logic              update_req;
  logic              update_ack;
  logic              dbginit_req;
  logic              dbginit_ack;
  logic [NUM_CL-1:0] cluster_cken;
  logic              grst_l;
  logic              gdbginit_l;
  logic              busy;

  modport master (
    output cken_target, update_req, dbginit_req,
    input  update_ack, dbginit_ack, cluster_cken, grst_l, gdbginit_l, busy
  );

  modport slave (
    input  cken_target, update_req, dbginit_req,
    output update_ack, dbginit_ack, cluster_cken, grst_l, gdbginit_l, busy
  );
endinterface

// File: rtl/cluster_cken_sequencer.sv
// Central sequencer for the per-cluster clock enables and the global
// reset/debug-init levels that feed the cluster headers. It applies a
// requested enable pattern one cluster at a time. Enable edges, both rising
// and falling, are spaced STAGGER cycles apart to bound supply di/dt.
// grst_l is released once, after a RST_HOLD hold that follows the first
// completed sequence. Timed gdbginit_l pulses are generated on request.
// Every output is a registered level (or a direct decode of the state
// register) in the gclk domain. The headers re-synchronize them.
// Ports:
//   gclk   : clock
//   arst_l : asynchronous active-low reset
//   bus    : slave side of cluster_cken_sequencer_if (requests in,
//            acknowledges, busy and header levels out)
module cluster_cken_sequencer #(
  parameter int NUM_CL   = 4,
  parameter int STAGGER  = 8,
  parameter int RST_HOLD = 16
) (
  input logic                      gclk,
  input logic                      arst_l,
  cluster_cken_sequencer_if.slave  bus
);

  localparam int MAXC = (STAGGER > RST_HOLD) ? STAGGER : RST_HOLD;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_CL > 1) ? $clog2(NUM_CL) : 1;

  typedef enum logic [2:0] {
    IDLE, STEP, WAIT, HOLD, UACK, DBG, DACK
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [NUM_CL-1:0] tgt, tgt_nx;
  logic [NUM_CL-1:0] cken_q, cken_nx;
  logic              grst_q, grst_nx;
  logic              gdbg_q, gdbg_nx;
  logic              adv;

  // State and datapath registers
  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      tgt    <= '0;
      cken_q <= '0;
      grst_q <= 1'b0;
      gdbg_q <= 1'b1;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      tgt    <= tgt_nx;
      cken_q <= cken_nx;
      grst_q <= grst_nx;
      gdbg_q <= gdbg_nx;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    tgt_nx   = tgt;
    cken_nx  = cken_q;
    grst_nx  = grst_q;
    gdbg_nx  = gdbg_q;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.update_req) begin
          tgt_nx   = bus.cken_target;
          idx_nx   = '0;
          state_nx = STEP;
        end else if (bus.dbginit_req) begin
          gdbg_nx  = 1'b0;
          cnt_nx   = CW'(RST_HOLD - 1);
          state_nx = DBG;
        end
      end
      STEP: begin
        if (tgt[idx] != cken_q[idx]) begin
          cken_nx[idx] = tgt[idx];
          // The STEP cycle itself is the first of the STAGGER cycles.
          if (STAGGER > 1) begin
            cnt_nx   = CW'(STAGGER - 1);
            state_nx = WAIT;
          end else begin
            adv = 1'b1;
          end
        end else begin
          adv = 1'b1;
        end
      end
      WAIT: begin
        // WAIT lasts STAGGER-1 cycles. It exits on the cycle that would
        // count down to zero, so the next STEP edge lands exactly STAGGER
        // cycles after the previous edge.
        cnt_nx = cnt - 1'b1;
        if (cnt <= CW'(1)) adv = 1'b1;
      end
      HOLD: begin
        if (cnt == '0) begin
          grst_nx  = 1'b1;
          state_nx = UACK;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      UACK: if (!bus.update_req) state_nx = IDLE;
      DBG: begin
        if (cnt == '0) begin
          gdbg_nx  = 1'b1;
          state_nx = DACK;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DACK: if (!bus.dbginit_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Move to the next cluster, or close out the sequence.
    if (adv) begin
      if (idx != IW'(NUM_CL - 1)) begin
        idx_nx   = idx + 1'b1;
        state_nx = STEP;
      end else if (!grst_q) begin
        cnt_nx   = CW'(RST_HOLD - 1);
        state_nx = HOLD;
      end else begin
        state_nx = UACK;
      end
    end
  end

  // Outputs: registered levels plus direct state decodes
  always_comb begin
    bus.cluster_cken = cken_q;
    bus.grst_l       = grst_q;
    bus.gdbginit_l   = gdbg_q;
    bus.update_ack   = (state == UACK);
    bus.dbginit_ack  = (state == DACK);
    bus.busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_cluster_cken_sequencer.sv
module tb_cluster_cken_sequencer;
  localparam int NUM_CL   = 4;
  localparam int STAGGER  = 8;
  localparam int RST_HOLD = 16;

  logic gclk;
  logic arst_l;
  int   checks;
  int   failures;

  // Reference state: what the headers should currently be receiving
  logic [NUM_CL-1:0] m_cken;
  logic              m_grst;

  cluster_cken_sequencer_if #(.NUM_CL(NUM_CL)) bus ();

  cluster_cken_sequencer #(
    .NUM_CL(NUM_CL), .STAGGER(STAGGER), .RST_HOLD(RST_HOLD)
  ) dut (
    .gclk   (gclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // Applies one update and checks every cycle against a schedule built from
  // the sequencing rules: each changed cluster costs STAGGER cycles and each
  // unchanged cluster costs one; the first release of grst_l adds RST_HOLD.
  task automatic run_update(input logic [NUM_CL-1:0] tgt, input bit drop, input string nm);
    int chg_t [NUM_CL];
    int t, ack_t, drop_k, hold;
    logic [NUM_CL-1:0] exp_ck;
    logic [3:0] exp_st;
    t = 1;
    for (int i = 0; i < NUM_CL; i++) begin
      if (tgt[i] != m_cken[i]) begin
        chg_t[i] = t + 1;
        t += STAGGER;
      end else begin
        chg_t[i] = 0;
        t += 1;
      end
    end
    if (!m_grst) t += RST_HOLD;
    ack_t  = t;
    drop_k = drop ? int'($urandom_range(1, ack_t - 1)) : 0;
    bus.cken_target = tgt;
    bus.update_req  = 1'b1;
    for (int k = 1; k <= ack_t; k++) begin
      tick();
      for (int i = 0; i < NUM_CL; i++)
        exp_ck[i] = (chg_t[i] != 0 && k >= chg_t[i]) ? tgt[i] : m_cken[i];
      exp_st = {m_grst | (k == ack_t), 1'b1, (k == ack_t), 1'b1};
      checks++;
      if (bus.cluster_cken !== exp_ck) begin
        failures++;
        $display("FAIL %s cken cyc=%0d: got %b expected %b", nm, k, bus.cluster_cken, exp_ck);
      end
      checks++;
      if ({bus.grst_l, bus.gdbginit_l, bus.update_ack, bus.busy} !== exp_st) begin
        failures++;
        $display("FAIL %s grst/gdbg/ack/busy cyc=%0d: got %b expected %b", nm, k,
                 {bus.grst_l, bus.gdbginit_l, bus.update_ack, bus.busy}, exp_st);
      end
      // The latched pattern must not follow the live input.
      bus.cken_target = NUM_CL'($urandom_range(0, (1 << NUM_CL) - 1));
      if (k == drop_k) bus.update_req = 1'b0;
    end
    m_cken = tgt;
    m_grst = 1'b1;
    if (!drop) begin
      hold = int'($urandom_range(0, 2));
      for (int h = 0; h < hold; h++) begin
        tick();
        checks++;
        if ({bus.update_ack, bus.busy} !== 2'b11) begin
          failures++;
          $display("FAIL %s ack held: got %b expected 11", nm, {bus.update_ack, bus.busy});
        end
      end
    end
    bus.update_req = 1'b0;
    tick();
    checks++;
    if ({bus.cluster_cken, bus.update_ack, bus.busy} !== {m_cken, 2'b00}) begin
      failures++;
      $display("FAIL %s idle after ack: got %b expected %b", nm,
               {bus.cluster_cken, bus.update_ack, bus.busy}, {m_cken, 2'b00});
    end
  endtask

  // gdbginit_l is low for RST_HOLD cycles after acceptance; the ack arrives with the release.
  task automatic run_dbg(input string nm);
    logic [2:0] exp_st;
    int hold;
    bus.dbginit_req = 1'b1;
    for (int k = 1; k <= RST_HOLD + 1; k++) begin
      tick();
      exp_st = {(k > RST_HOLD), (k == RST_HOLD + 1), 1'b1};
      checks++;
      if ({bus.gdbginit_l, bus.dbginit_ack, bus.busy} !== exp_st) begin
        failures++;
        $display("FAIL %s gdbg/ack/busy cyc=%0d: got %b expected %b", nm, k,
                 {bus.gdbginit_l, bus.dbginit_ack, bus.busy}, exp_st);
      end
      checks++;
      if ({bus.cluster_cken, bus.grst_l, bus.update_ack} !== {m_cken, m_grst, 1'b0}) begin
        failures++;
        $display("FAIL %s levels during dbg cyc=%0d: got %b expected %b", nm, k,
                 {bus.cluster_cken, bus.grst_l, bus.update_ack}, {m_cken, m_grst, 1'b0});
      end
    end
    hold = int'($urandom_range(0, 1));
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (bus.dbginit_ack !== 1'b1) begin
        failures++;
        $display("FAIL %s dack held: got %b expected 1", nm, bus.dbginit_ack);
      end
    end
    bus.dbginit_req = 1'b0;
    tick();
    checks++;
    if ({bus.gdbginit_l, bus.dbginit_ack, bus.busy} !== 3'b100) begin
      failures++;
      $display("FAIL %s idle after dack: got %b expected 100", nm,
               {bus.gdbginit_l, bus.dbginit_ack, bus.busy});
    end
  endtask

  // Check that the outputs hold their reset values, with arst_l asserted.
  task automatic check_reset_vals(input string nm);
    checks++;
    if ({bus.cluster_cken, bus.grst_l, bus.gdbginit_l, bus.update_ack, bus.dbginit_ack, bus.busy}
        !== {{NUM_CL{1'b0}}, 5'b01000}) begin
      failures++;
      $display("FAIL %s reset values: got %b expected %b", nm,
               {bus.cluster_cken, bus.grst_l, bus.gdbginit_l, bus.update_ack, bus.dbginit_ack, bus.busy},
               {{NUM_CL{1'b0}}, 5'b01000});
    end
  endtask

  task automatic test_reset();
    bus.cken_target = '0;
    bus.update_req  = 1'b0;
    bus.dbginit_req = 1'b0;
    arst_l = 1'b1;
    #1 arst_l = 1'b0;
    #20;
    check_reset_vals("reset");
    m_cken = '0;
    m_grst = 1'b0;
    @(posedge gclk);
    #3 arst_l = 1'b1;
    tick();
  endtask

  task automatic test_power_up();
    run_update(4'b1111, 1'b0, "power_up");
  endtask

  task automatic test_partial_off();
    run_update(4'b0101, 1'b0, "partial_off");
  endtask

  task automatic test_no_change();
    run_update(m_cken, 1'b0, "no_change");
  endtask

  task automatic test_back_to_back();
    bus.dbginit_req = 1'b1;
    run_update(4'b1100, 1'b0, "concurrent_upd");
    run_dbg("concurrent_dbg");
  endtask

  task automatic test_reset_in_wait();
    run_update(4'b0000, 1'b0, "clear_all");
    // Start an all-on sequence and hit reset while waiting after cluster 1.
    bus.cken_target = 4'b1111;
    bus.update_req  = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (bus.cluster_cken !== 4'b0011) begin
      failures++;
      $display("FAIL wait_pre_reset cken: got %b expected 0011", bus.cluster_cken);
    end
    #2 arst_l = 1'b0;
    #1 check_reset_vals("reset_in_wait");
    bus.update_req = 1'b0;
    m_cken = '0;
    m_grst = 1'b0;
    @(posedge gclk);
    #3 arst_l = 1'b1;
    run_update(4'b0110, 1'b0, "restart_after_reset");
  endtask

  task automatic test_reset_in_dbg();
    bus.dbginit_req = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (bus.gdbginit_l !== 1'b0) begin
      failures++;
      $display("FAIL dbg_pre_reset gdbg: got %b expected 0", bus.gdbginit_l);
    end
    #2 arst_l = 1'b0;
    #1 check_reset_vals("reset_in_dbg");
    bus.dbginit_req = 1'b0;
    m_cken = '0;
    m_grst = 1'b0;
    @(posedge gclk);
    #3 arst_l = 1'b1;
    // Unchanged pattern with grst_l low still goes through the hold.
    run_update(4'b0000, 1'b0, "no_change_grst0");
  endtask

  task automatic test_drop_mid();
    run_update(4'b1011, 1'b1, "drop_mid");
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 8; n++) begin
      r = int'($urandom_range(0, 3));
      if (r == 3) run_dbg("rand_dbg");
      else run_update(NUM_CL'($urandom_range(0, (1 << NUM_CL) - 1)), r == 2, "rand_upd");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_power_up();
    test_partial_off();
    test_no_change();
    test_back_to_back();
    test_reset_in_wait();
    test_reset_in_dbg();
    test_drop_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
